// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, bus register map and default rates.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic [1:0] ADDR_RXTX   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; reset value is selectable
// so idle-high lines do not produce a false edge when reset is released.
module spart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: recovers 8N1 frames from rxd using the baud generator's oversample tick
// and holds the last byte with data-available, framing and overrun status for the bus.
module spart_rx #(
    parameter int unsigned OVERSAMPLE = spart_pkg::OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = spart_pkg::DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rxd,
    input  logic                 iocs,
    input  logic                 iorw,
    input  logic [1:0]           ioaddr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun
);

    import spart_pkg::*;

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    logic                 rd_clear;
    rx_state_t            state;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;

    spart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_rxd_sync (
        .clk(clk),
        .rst(rst),
        .d  (rxd),
        .q  (rxs)
    );

    assign rd_clear = iocs & iorw & (ioaddr == ADDR_RXTX);

    // Frame recovery advances on oversample ticks; read-clear acts every cycle but
    // is overridden by a frame completing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (rd_clear) begin
                rda         <= 1'b0;
                framing_err <= 1'b0;
                overrun     <= 1'b0;
            end

            if (enable) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            tick  <= '0;
                            state <= START;
                        end
                    end

                    START: begin
                        if (tick == TICK_MID) begin
                            tick    <= '0;
                            bit_cnt <= '0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end

                    // Tick counter wraps naturally, so each sample lands one bit period later.
                    DATA: begin
                        tick <= tick + TICK_W'(1);
                        if (tick == TICK_LAST) begin
                            shift   <= {rxs, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end
                    end

                    STOP: begin
                        tick <= tick + TICK_W'(1);
                        if (tick == TICK_LAST) begin
                            rx_data     <= shift;
                            rda         <= 1'b1;
                            framing_err <= !rxs || (framing_err && !rd_clear);
                            overrun     <= !rd_clear && (rda || overrun);
                            state       <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: serial frames driven bit-by-bit, results compared
// against a frame-level model of the byte register and status flags.
module tb_spart_rx;

    localparam int unsigned OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rxd;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int div   = 0;
    int ecnt  = 0;
    int lat;

    logic [7:0] m_data;
    logic       m_rda;
    logic       m_fe;
    logic       m_ov;

    spart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rxd        (rxd),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .rx_data    (rx_data),
        .rda        (rda),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Baud tick: every clk for divisor 0, otherwise one tick every div+1 clocks.
    always @(negedge clk) begin
        if (div == 0) begin
            enable = 1'b1;
        end else begin
            enable = (ecnt == 0);
            ecnt   = (ecnt >= div) ? 0 : ecnt + 1;
        end
    end

    function automatic logic [10:0] obs();
        return {rda, framing_err, overrun, rx_data};
    endfunction

    function automatic logic [10:0] expv();
        return {m_rda, m_fe, m_ov, m_data};
    endfunction

    function automatic void model_reset();
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_fe   = 1'b0;
        m_ov   = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic stop_ok, input logic rd_same);
        if (rd_same) begin
            m_fe = !stop_ok;
            m_ov = 1'b0;
        end else begin
            m_fe = m_fe | !stop_ok;
            m_ov = m_ov | m_rda;
        end
        m_data = d;
        m_rda  = 1'b1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_access(input logic rw, input logic [1:0] addr);
        @(negedge clk);
        iocs   = 1'b1;
        iorw   = rw;
        ioaddr = addr;
        @(negedge clk);
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        if (rw && addr == 2'b00) begin
            m_rda = 1'b0;
            m_fe  = 1'b0;
            m_ov  = 1'b0;
        end
    endtask

    // Drives one full frame; optional one-cycle data read or reset at a given cycle offset.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int rd_at, input int rst_at);
        int         bit_clk;
        logic [9:0] frame;
        bit_clk = OS * (div + 1);
        frame   = {stop_bit, d, 1'b0};
        lat     = -1;
        for (int c = 0; c < 10 * bit_clk; c++) begin
            @(negedge clk);
            if (lat < 0 && rda === 1'b1) lat = c;
            rxd = frame[c / bit_clk];
            if (c == rd_at) begin
                iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
            end else begin
                iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
            end
            rst = (c == rst_at);
        end
        @(negedge clk);
        if (lat < 0 && rda === 1'b1) lat = 10 * bit_clk;
        rxd  = 1'b1;
        iocs = 1'b0;
        iorw = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        div    = 0;
        rst    = 1'b1;
        rxd    = 1'b1;
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        idle(5);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            idle(100);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL reset_idle[%0d] got=%b exp=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, -1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        total++;
        if (lat < 154 || lat > 156) begin
            bad++;
            $display("FAIL latency_a5 got=%0d exp=154..156", lat);
        end
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL frame_a5 got=%b exp=%b", obs(), expv());
        end
        idle(16);
        bus_access(1'b1, 2'b00);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL read_clear_a5 got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL glitch_ignored got=%b exp=%b", obs(), expv());
        end
        send_frame(8'h3C, 1'b1, -1, -1);
        model_frame(8'h3C, 1'b1, 1'b0);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL frame_3c got=%b exp=%b", obs(), expv());
        end
        bus_access(1'b1, 2'b00);
    endtask

    task automatic test_framing();
        send_frame(8'h55, 1'b0, -1, -1);
        model_frame(8'h55, 1'b0, 1'b0);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL framing_55 got=%b exp=%b", obs(), expv());
        end
        idle(2 * OS);
        bus_access(1'b0, 2'b01);
        bus_access(1'b1, 2'b01);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL status_read_keeps got=%b exp=%b", obs(), expv());
        end
        bus_access(1'b1, 2'b00);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL framing_clear got=%b exp=%b", obs(), expv());
        end
    endtask

    task automatic test_back_to_back();
        int l1;
        send_frame(8'h11, 1'b1, -1, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, -1, -1);
        model_frame(8'h22, 1'b1, 1'b0);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL overrun_22 got=%b exp=%b", obs(), expv());
        end
        bus_access(1'b1, 2'b00);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL overrun_clear got=%b exp=%b", obs(), expv());
        end
        send_frame(8'h11, 1'b1, -1, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        l1 = lat;
        total++;
        if (l1 < 154 || l1 > 156) begin
            bad++;
            $display("FAIL latency_11 got=%0d exp=154..156", l1);
        end
        send_frame(8'h22, 1'b1, l1 - 1, -1);
        model_frame(8'h22, 1'b1, 1'b1);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL read_on_completion got=%b exp=%b", obs(), expv());
        end
        bus_access(1'b1, 2'b00);
    endtask

    task automatic test_reset_midframe(input int d);
        int bit_clk;
        int lo;
        int hi;
        div     = d;
        bit_clk = OS * (d + 1);
        idle(bit_clk);
        send_frame(8'hFF, 1'b1, -1, 5 * bit_clk + bit_clk / 2);
        model_reset();
        idle(bit_clk);
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL abort_ff_div%0d got=%b exp=%b", d, obs(), expv());
        end
        send_frame(8'h81, 1'b1, -1, -1);
        model_frame(8'h81, 1'b1, 1'b0);
        lo = (d == 0) ? 154 : 152 * (d + 1);
        hi = (d == 0) ? 156 : 155 * (d + 1) + d + 2;
        total++;
        if (lat < lo || lat > hi) begin
            bad++;
            $display("FAIL latency_81_div%0d got=%0d exp=%0d..%0d", d, lat, lo, hi);
        end
        total++;
        if (obs() !== expv()) begin
            bad++;
            $display("FAIL frame_81_div%0d got=%b exp=%b", d, obs(), expv());
        end
        bus_access(1'b1, 2'b00);
        div = 0;
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop_ok;
        int         act;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       div = 0;
                1:       div = 1;
                default: div = 3;
            endcase
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok, -1, -1);
            model_frame(d, stop_ok, 1'b0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL rand_frame[%0d] got=%b exp=%b", i, obs(), expv());
            end
            if (!stop_ok) idle(2 * OS * (div + 1));
            else idle(int'($urandom_range(0, 20)));
            act = int'($urandom_range(0, 3));
            if (act != 0) begin
                if (act == 1) bus_access(1'b1, 2'b00);
                else if (act == 2) bus_access(1'b1, 2'b01);
                else bus_access(1'b0, 2'b00);
                total++;
                if (obs() !== expv()) begin
                    bad++;
                    $display("FAIL rand_bus[%0d] act=%0d got=%b exp=%b", i, act, obs(), expv());
                end
            end
        end
        div = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe(0);
        test_reset_midframe(4);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
